// File: rtl/tff_bank_counter.sv
// WIDTH-bit bank of T cells with runtime toggle/up/down modes, parallel load,
// terminal-count flag and a registered wrap/limit pulse.

module tff_cell #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic din,
  input  logic tog,
  output logic q
);
  always_ff @(posedge clk) begin
    if (!rstn)     q <= RST_VAL;
    else if (load) q <= din;
    else           q <= q ^ tog;
  end
endmodule

module tff_bank_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             ovf
);
  localparam logic [1:0] M_HOLD = 2'b00, M_TOG = 2'b01, M_UP = 2'b10, M_DN = 2'b11;

  logic [WIDTH-1:0] up_m, dn_m, mask;
  logic             at_max, at_min;

  // Ripple-and chains: bit i toggles once every lower bit is at the carry/borrow value.
  assign up_m[0] = 1'b1;
  assign dn_m[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign up_m[i] = up_m[i-1] &  q[i-1];
    assign dn_m[i] = dn_m[i-1] & ~q[i-1];
  end

  assign at_max = &q;
  assign at_min = ~|q;
  // A load pre-empts any count step, so no terminal count is reported for it.
  assign tc = en & ~load & (((mode == M_UP) & at_max) | ((mode == M_DN) & at_min));

  always_comb begin
    mask = '0;
    if (en) begin
      case (mode)
        M_TOG:   mask = t;
        M_UP:    mask = (SATURATE && at_max) ? '0 : up_m;
        M_DN:    mask = (SATURATE && at_min) ? '0 : dn_m;
        default: mask = '0;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
      .clk  (clk),
      .rstn (rstn),
      .load (load),
      .din  (din[i]),
      .tog  (mask[i]),
      .q    (q[i])
    );
  end

  assign q_bar = ~q;

  // tc already excludes load, so it marks exactly the count steps taken at the limit.
  always_ff @(posedge clk) begin
    if (!rstn) ovf <= 1'b0;
    else       ovf <= tc;
  end
endmodule

// File: tb/tb_tff_bank_counter.sv
// Directed checks of tff_bank_counter: wrap and saturating variants driven
// together, plus a two-stage cascade.

module tb_tff_bank_counter;
  logic       clk = 1'b0;
  logic       rstn, en, load;
  logic [1:0] mode;
  logic [3:0] t, din;
  logic [3:0] qa, qba, qs, qbs;
  logic       tca, ovfa, tcs, ovfs;

  logic       rstn_c, en_c;
  logic [3:0] q_lo, q_hi, qb_lo, qb_hi;
  logic       tc_lo, tc_hi, ovf_lo, ovf_hi;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .t(t), .load(load), .din(din),
    .q(qa), .q_bar(qba), .tc(tca), .ovf(ovfa));

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .t(t), .load(load), .din(din),
    .q(qs), .q_bar(qbs), .tc(tcs), .ovf(ovfs));

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rstn(rstn_c), .en(en_c), .mode(2'b10), .t(4'h0), .load(1'b0), .din(4'h0),
    .q(q_lo), .q_bar(qb_lo), .tc(tc_lo), .ovf(ovf_lo));

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rstn(rstn_c), .en(tc_lo), .mode(2'b10), .t(4'h0), .load(1'b0), .din(4'h0),
    .q(q_hi), .q_bar(qb_hi), .tc(tc_hi), .ovf(ovf_hi));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; mode = 2'b00; t = 4'h0; load = 1'b0; din = 4'h0;
    rstn_c = 1'b0; en_c = 1'b0;
    #1;

    // Reset
    step(2);
    chk("rst_q", qa, 4'h5);
    chk("rst_qbar", qba, 4'hA);
    chk("rst_ovf", ovfa, 1'b0);
    chk("rst_q_sat", qs, 4'h5);
    rstn = 1'b1;
    step();
    chk("rel_hold", qa, 4'h5);

    // Toggle
    load = 1'b1; din = 4'h0;
    step();
    load = 1'b0;
    chk("load0", qa, 4'h0);
    mode = 2'b01; en = 1'b1; t = 4'b1010;
    step();
    chk("tog1", qa, 4'hA);
    chk("tog1_tc", tca, 1'b0);
    chk("tog1_ovf", ovfa, 1'b0);
    step();
    chk("tog2", qa, 4'h0);
    step();
    chk("tog3", qa, 4'hA);
    t = 4'h0;
    step();
    chk("tog_hold", qa, 4'hA);
    chk("tog_hold_ovf", ovfa, 1'b0);

    // Up count: wrap variant vs saturating variant
    load = 1'b1; din = 4'hE;
    step();
    load = 1'b0;
    mode = 2'b10; en = 1'b1;
    step();
    chk("up_F", qa, 4'hF);
    chk("up_F_tc", tca, 1'b1);
    chk("up_F_ovf", ovfa, 1'b0);
    step();
    chk("up_wrap", qa, 4'h0);
    chk("up_wrap_ovf", ovfa, 1'b1);
    chk("sat_hold1", qs, 4'hF);
    chk("sat_ovf1", ovfs, 1'b1);
    chk("up_wrap_tc", tca, 1'b0);
    step();
    chk("up_1", qa, 4'h1);
    chk("up_1_ovf", ovfa, 1'b0);
    chk("sat_hold2", qs, 4'hF);
    chk("sat_ovf2", ovfs, 1'b1);
    en = 1'b0;
    step();
    chk("sat_en0_ovf", ovfs, 1'b0);
    chk("sat_en0_q", qs, 4'hF);
    chk("en0_hold", qa, 4'h1);

    // Down count
    mode = 2'b11; en = 1'b1;
    step();
    chk("dn_0", qa, 4'h0);
    chk("dn_0_tc", tca, 1'b1);
    chk("dn_0_ovf", ovfa, 1'b0);
    step();
    chk("dn_wrap", qa, 4'hF);
    chk("dn_wrap_ovf", ovfa, 1'b1);
    chk("sat_dn", qs, 4'hD);

    // Priority: load over count, reset over load
    mode = 2'b10; en = 1'b1; load = 1'b1; din = 4'h3;
    step();
    chk("pri_load", qa, 4'h3);
    chk("pri_load_ovf", ovfa, 1'b0);
    load = 1'b1; din = 4'h9; rstn = 1'b0;
    step();
    chk("pri_rst", qa, 4'h5);
    chk("pri_rst_ovf", ovfa, 1'b0);
    rstn = 1'b1; load = 1'b0; en = 1'b0;

    // Cascade
    rstn_c = 1'b0;
    step();
    rstn_c = 1'b1; en_c = 1'b1;
    step(10);
    chk("cas_10", {q_hi, q_lo}, 8'h0A);
    step(5);
    chk("cas_15", {q_hi, q_lo}, 8'h0F);
    chk("cas_15_tc", tc_lo, 1'b1);
    step(5);
    chk("cas_20", {q_hi, q_lo}, 8'h14);
    rstn_c = 1'b0;
    step();
    chk("cas_rst", {q_hi, q_lo}, 8'h00);
    rstn_c = 1'b1;
    step();
    chk("cas_restart", {q_hi, q_lo}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
